text_overlay_engine: RTL and testbench

Parametrised, clocked successor to the combinational text generator: overlays a COLS×ROWS grid of 8×8 ASCII glyphs, scaled by 2^SCALE_LOG2, onto the 320×240 RGB565 pixel stream. The block holds an internal character buffer written over a valid/ready port. Glyph bitmaps come from an external combinational font ROM. Output is a two-stage pipeline feeding the display compositor.

---
 rtl/text_overlay_engine.sv | 173 +++++++++++++++++
 tb/tb_text_overlay_engine.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_overlay_engine.sv
// Text overlay engine: character buffer with a clear sweep and a two-stage
// pixel pipeline that turns (x, y) into RGB565 glyph pixels via an external
// font ROM.
module text_overlay_engine #(
  parameter int unsigned COLS           = 40,
  parameter int unsigned ROWS           = 30,
  parameter int unsigned SCALE_LOG2     = 0,
  parameter int unsigned X0             = 0,
  parameter int unsigned Y0             = 0,
  parameter logic [15:0] FG             = 16'hFFFF,
  parameter logic [15:0] BG             = 16'h0000,
  parameter bit          BG_TRANSPARENT = 1'b0,
  localparam int unsigned COL_W         = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pix_valid,
  input  logic [8:0]       x_pixel,
  input  logic [7:0]       y_pixel,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [6:0]       wr_char,
  input  logic             clear,
  output logic             busy,
  output logic [9:0]       font_addr,
  input  logic [7:0]       font_data,
  output logic [15:0]      pixel,
  output logic             active,
  output logic             pix_valid_out
);

  localparam int unsigned DEPTH   = COLS * ROWS;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CELL_SH = 3 + SCALE_LOG2;
  localparam int unsigned REG_W   = (COLS * 8) << SCALE_LOG2;
  localparam int unsigned REG_H   = (ROWS * 8) << SCALE_LOG2;
  localparam logic [6:0]  SPACE   = 7'h20;

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [6:0]       mem_q [DEPTH];
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [6:0]       wdata;

  logic             wr_in_range;
  logic [IDX_W-1:0] wr_idx;

  logic [31:0]      dx, dy;
  logic             in_region;
  logic [IDX_W-1:0] rd_idx;

  logic             s1_on_q, s1_valid_q;
  logic [2:0]       gx_q, gy_q;
  logic [6:0]       rd_char_q;
  logic             fb;

  logic [15:0]      pixel_q;
  logic             active_q, pvo_q;

  assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign wr_idx      = IDX_W'(32'(wr_row) * COLS + 32'(wr_col));

  assign busy        = (state_q == ST_CLEAR);
  assign wr_ready    = (state_q == ST_IDLE);

  // State and sweep index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, sweep index and buffer write-port arbitration
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we      = 1'b0;
    waddr   = idx_q;
    wdata   = SPACE;
    case (state_q)
      ST_CLEAR: begin
        we = 1'b1;
        if (clear) begin
          idx_d = '0;
        end else if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (wr_valid && wr_in_range) begin
          we    = 1'b1;
          waddr = wr_idx;
          wdata = wr_char;
        end
        if (clear) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // Character buffer write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Region test and cell lookup; out-of-region reads are parked at index 0
  assign dx        = 32'(x_pixel) - X0;
  assign dy        = 32'(y_pixel) - Y0;
  assign in_region = (32'(x_pixel) >= X0) && (dx < REG_W) &&
                     (32'(y_pixel) >= Y0) && (dy < REG_H);
  assign rd_idx    = in_region ? IDX_W'((dy >> CELL_SH) * COLS + (dx >> CELL_SH)) : '0;

  // Stage 1: qualify the pixel, latch glyph coordinates, read the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_on_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      rd_char_q  <= '0;
    end else begin
      s1_on_q    <= en && in_region && (state_q == ST_IDLE);
      s1_valid_q <= pix_valid;
      gx_q       <= 3'(dx >> SCALE_LOG2);
      gy_q       <= 3'(dy >> SCALE_LOG2);
      rd_char_q  <= mem_q[rd_idx];
    end
  end

  assign font_addr = {rd_char_q, gy_q};
  assign fb        = font_data[3'd7 - gx_q];

  // Stage 2: colour the pixel and mark overlay ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q  <= '0;
      active_q <= 1'b0;
      pvo_q    <= 1'b0;
    end else begin
      pixel_q  <= s1_on_q ? (fb ? FG : BG) : 16'h0000;
      active_q <= s1_on_q && (fb || !BG_TRANSPARENT);
      pvo_q    <= s1_valid_q;
    end
  end

  assign pixel         = pixel_q;
  assign active        = active_q;
  assign pix_valid_out = pvo_q;

endmodule

// File: tb/tb_text_overlay_engine.sv
// Bench for text_overlay_engine: a default instance and a scaled, offset,
// transparent-background instance share all inputs and are compared against
// a behavioural pixel model.
module tb_text_overlay_engine;

  localparam logic [15:0] D1_FG = 16'hFFFF;
  localparam logic [15:0] D1_BG = 16'h0000;
  localparam logic [15:0] D2_FG = 16'hF800;
  localparam logic [15:0] D2_BG = 16'h07E0;

  typedef struct {
    int x;
    int y;
    bit en;
    bit pv;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n, en, pix_valid, wr_valid, clear;
  logic [8:0]  x_pixel;
  logic [7:0]  y_pixel;
  logic [5:0]  wr_col;
  logic [4:0]  wr_row;
  logic [6:0]  wr_char;

  logic        wr_ready1, busy1, act1, pvo1;
  logic        wr_ready2, busy2, act2, pvo2;
  logic [9:0]  fa1, fa2;
  logic [7:0]  fd1, fd2;
  logic [15:0] px1, px2;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [6:0]  model_buf [1200];
  item_t       scan_q [$];
  logic [17:0] obs1 [], obs2 [];
  logic [9:0]  obsfa1 [], obsfa2 [];

  always #5 clk = ~clk;

  // Arbitrary but fixed font content
  function automatic logic [7:0] rom(input logic [9:0] a);
    logic [15:0] t;
    t = 16'({6'd0, a}) * 16'd40503;
    return t[15:8] ^ a[7:0];
  endfunction

  assign fd1 = rom(fa1);
  assign fd2 = rom(fa2);

  text_overlay_engine u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_valid(pix_valid),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_col(wr_col), .wr_row(wr_row),
    .wr_char(wr_char), .clear(clear), .busy(busy1),
    .font_addr(fa1), .font_data(fd1),
    .pixel(px1), .active(act1), .pix_valid_out(pvo1)
  );

  text_overlay_engine #(
    .SCALE_LOG2(1), .X0(16), .Y0(8), .FG(D2_FG), .BG(D2_BG), .BG_TRANSPARENT(1'b1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_valid(pix_valid),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_col(wr_col), .wr_row(wr_row),
    .wr_char(wr_char), .clear(clear), .busy(busy2),
    .font_addr(fa2), .font_data(fd2),
    .pixel(px2), .active(act2), .pix_valid_out(pvo2)
  );

  // Behavioural pixel model: vec = {pixel, active, pix_valid_out}
  function automatic void model(input bit d2, input item_t it, input bit bsy,
                                output logic [17:0] vec, output bit fav,
                                output logic [9:0] fa);
    int scale, x0, y0, dx, dy, w, h, cc, cr, gx, gy;
    bit transp, inr, fb, on;
    logic [15:0] fg, bg, px;
    logic [7:0] bits;
    scale = d2 ? 1 : 0;
    x0 = d2 ? 16 : 0;
    y0 = d2 ? 8 : 0;
    transp = d2;
    fg = d2 ? D2_FG : D1_FG;
    bg = d2 ? D2_BG : D1_BG;
    dx = it.x - x0;
    dy = it.y - y0;
    w = 320 << scale;
    h = 240 << scale;
    inr = (it.x >= x0) && (dx < w) && (it.y >= y0) && (dy < h);
    fa = '0;
    fb = 1'b0;
    if (inr) begin
      cc = dx >> (3 + scale);
      cr = dy >> (3 + scale);
      gx = (dx >> scale) % 8;
      gy = (dy >> scale) % 8;
      fa = {model_buf[cr * 40 + cc], 3'(gy)};
      bits = rom(fa);
      fb = bits[7 - gx];
    end
    fav = inr && !bsy;
    on = inr && it.en && !bsy;
    px = on ? (fb ? fg : bg) : 16'h0000;
    vec = {px, on && (fb || !transp), it.pv};
  endfunction

  task automatic idle_inputs();
    en = 1'b0; pix_valid = 1'b0; x_pixel = '0; y_pixel = '0;
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; clear = 1'b0;
  endtask

  task automatic do_write(input int col, input int row, input int ch);
    wr_valid = 1'b1;
    wr_col = 6'(col);
    wr_row = 5'(row);
    wr_char = 7'(ch);
    @(negedge clk);
    wr_valid = 1'b0;
    if (col < 40 && row < 30) model_buf[row * 40 + col] = 7'(ch);
  endtask

  // Drives scan_q one pixel per clock and captures outputs aligned to each item
  task automatic run_scan();
    int n;
    n = scan_q.size();
    obs1 = new[n]; obs2 = new[n]; obsfa1 = new[n]; obsfa2 = new[n];
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 1 && i <= n) begin
        obsfa1[i-1] = fa1;
        obsfa2[i-1] = fa2;
      end
      if (i >= 2) begin
        obs1[i-2] = {px1, act1, pvo1};
        obs2[i-2] = {px2, act2, pvo2};
      end
      if (i < n) begin
        x_pixel = 9'(scan_q[i].x);
        y_pixel = 8'(scan_q[i].y);
        en = scan_q[i].en;
        pix_valid = scan_q[i].pv;
      end else begin
        en = 1'b0;
        pix_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_busy(output int cnt, output bit bad);
    cnt = 0;
    bad = 1'b0;
    while (busy1 === 1'b1 && cnt < 3000) begin
      if (wr_ready1 !== 1'b0 || busy2 !== 1'b1 || wr_ready2 !== 1'b0) bad = 1'b1;
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cnt;
    bit bad;
    logic [29:0] exp_rst;
    exp_rst = {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000};
    idle_inputs();
    pix_valid = 1'b1;
    en = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    n_tests++;
    if ({px1, act1, pvo1, busy1, wr_ready1, fa1} !== exp_rst) begin
      n_fail++;
      $display("FAIL reset_vals d1: got %h exp %h", {px1, act1, pvo1, busy1, wr_ready1, fa1}, exp_rst);
    end
    n_tests++;
    if ({px2, act2, pvo2, busy2, wr_ready2, fa2} !== exp_rst) begin
      n_fail++;
      $display("FAIL reset_vals d2: got %h exp %h", {px2, act2, pvo2, busy2, wr_ready2, fa2}, exp_rst);
    end
    repeat (3) @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    wait_busy(cnt, bad);
    n_tests++;
    if (cnt != 1200) begin
      n_fail++;
      $display("FAIL reset_clear_len: got %0d cycles exp 1200", cnt);
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_ready_low: got wr_ready/busy glitch during sweep exp ready=0 busy=1");
    end
    n_tests++;
    if ({busy1, wr_ready1, busy2, wr_ready2} !== 4'b0101) begin
      n_fail++;
      $display("FAIL reset_idle: got %b exp 0101", {busy1, wr_ready1, busy2, wr_ready2});
    end
    for (int i = 0; i < 1200; i++) model_buf[i] = 7'h20;
  endtask

  task automatic test_glyph_a();
    logic [17:0] ev;
    bit fv;
    logic [9:0] ef;
    n_tests++;
    if (wr_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL glyph_a ready: got %b exp 1", wr_ready1);
    end
    do_write(0, 0, 'h41);
    scan_q.delete();
    for (int i = 0; i < 64; i++) scan_q.push_back('{x: i % 8, y: i / 8, en: 1'b1, pv: 1'b1});
    run_scan();
    foreach (scan_q[i]) begin
      model(1'b0, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs1[i] !== ev) begin
        n_fail++;
        $display("FAIL glyph_a pix d1 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs1[i], ev);
      end
      n_tests++;
      if (obsfa1[i] !== ef || ef[9:3] !== 7'h41) begin
        n_fail++;
        $display("FAIL glyph_a fa d1 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obsfa1[i], ef);
      end
      model(1'b1, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs2[i] !== ev) begin
        n_fail++;
        $display("FAIL glyph_a pix d2 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs2[i], ev);
      end
    end
  endtask

  task automatic test_scaled_region();
    logic [17:0] ev;
    bit fv;
    logic [9:0] ef;
    int pts [10][2];
    pts = '{'{15, 8}, '{16, 8}, '{17, 8}, '{18, 8}, '{31, 8}, '{32, 8},
            '{16, 9}, '{16, 23}, '{16, 24}, '{16, 7}};
    scan_q.delete();
    for (int i = 0; i < 10; i++) scan_q.push_back('{x: pts[i][0], y: pts[i][1], en: 1'b1, pv: 1'b1});
    for (int x = 0; x < 320; x++) scan_q.push_back('{x: x, y: 10, en: 1'b1, pv: 1'b1});
    run_scan();
    foreach (scan_q[i]) begin
      model(1'b1, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs2[i] !== ev) begin
        n_fail++;
        $display("FAIL scaled pix d2 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs2[i], ev);
      end
      if (fv) begin
        n_tests++;
        if (obsfa2[i] !== ef) begin
          n_fail++;
          $display("FAIL scaled fa d2 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obsfa2[i], ef);
        end
      end
      model(1'b0, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs1[i] !== ev) begin
        n_fail++;
        $display("FAIL scaled pix d1 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs1[i], ev);
      end
    end
  endtask

  task automatic test_transparent_en();
    logic [17:0] ev;
    bit fv;
    logic [9:0] ef;
    for (int c = 1; c < 4; c++) do_write(c, 0, 33 + int'($urandom_range(0, 93)));
    scan_q.delete();
    for (int x = 0; x < 96; x++)
      scan_q.push_back('{x: x, y: 12, en: ((x / 7) % 2) == 0, pv: (x % 11) != 5});
    run_scan();
    foreach (scan_q[i]) begin
      model(1'b1, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs2[i] !== ev) begin
        n_fail++;
        $display("FAIL transp pix d2 x=%0d en=%0d: got %h exp %h", scan_q[i].x, scan_q[i].en, obs2[i], ev);
      end
      model(1'b0, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs1[i] !== ev) begin
        n_fail++;
        $display("FAIL transp pix d1 x=%0d en=%0d: got %h exp %h", scan_q[i].x, scan_q[i].en, obs1[i], ev);
      end
    end
  endtask

  task automatic test_bad_write();
    logic [17:0] ev;
    bit fv;
    logic [9:0] ef;
    n_tests++;
    if (wr_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_write ready: got %b exp 1", wr_ready1);
    end
    do_write(45, 3, 'h5A);
    n_tests++;
    if ({wr_ready1, busy1} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_write handshake: got ready/busy %b exp 10", {wr_ready1, busy1});
    end
    do_write(2, 31, 'h5A);
    scan_q.delete();
    for (int i = 0; i < 64; i++) scan_q.push_back('{x: 40 + i % 8, y: 32 + i / 8, en: 1'b1, pv: 1'b1});
    run_scan();
    foreach (scan_q[i]) begin
      model(1'b0, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs1[i] !== ev || obsfa1[i] !== ef) begin
        n_fail++;
        $display("FAIL bad_write cell (%0d,%0d): got %h/%h exp %h/%h",
                 scan_q[i].x, scan_q[i].y, obs1[i], obsfa1[i], ev, ef);
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] ev;
    bit fv;
    logic [9:0] ef;
    for (int i = 0; i < 24; i++)
      do_write(int'($urandom_range(0, 39)), int'($urandom_range(0, 29)), int'($urandom_range(0, 127)));
    scan_q.delete();
    for (int i = 0; i < 300; i++)
      scan_q.push_back('{x: int'($urandom_range(0, 319)), y: int'($urandom_range(0, 239)),
                         en: ($urandom % 4) != 0, pv: ($urandom % 2) != 0});
    run_scan();
    foreach (scan_q[i]) begin
      model(1'b0, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs1[i] !== ev) begin
        n_fail++;
        $display("FAIL random pix d1 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs1[i], ev);
      end
      n_tests++;
      if (obsfa1[i] !== ef) begin
        n_fail++;
        $display("FAIL random fa d1 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obsfa1[i], ef);
      end
      model(1'b1, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs2[i] !== ev) begin
        n_fail++;
        $display("FAIL random pix d2 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs2[i], ev);
      end
    end
  endtask

  task automatic test_clear_restart();
    logic [17:0] ev;
    bit fv;
    logic [9:0] ef;
    int cnt;
    bit bad;
    // clear together with an accepted write: the write is swept away
    clear = 1'b1;
    wr_valid = 1'b1; wr_col = 6'd0; wr_row = 5'd0; wr_char = 7'h51;
    @(negedge clk);
    clear = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < 1200; i++) model_buf[i] = 7'h20;
    n_tests++;
    if ({busy1, wr_ready1} !== 2'b10) begin
      n_fail++;
      $display("FAIL clear_start: got busy/ready %b exp 10", {busy1, wr_ready1});
    end
    scan_q.delete();
    for (int i = 0; i < 40; i++)
      scan_q.push_back('{x: int'($urandom_range(0, 319)), y: int'($urandom_range(0, 239)), en: 1'b1, pv: 1'b1});
    run_scan();
    foreach (scan_q[i]) begin
      model(1'b0, scan_q[i], 1'b1, ev, fv, ef);
      n_tests++;
      if (obs1[i] !== ev) begin
        n_fail++;
        $display("FAIL busy_gate d1 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs1[i], ev);
      end
      model(1'b1, scan_q[i], 1'b1, ev, fv, ef);
      n_tests++;
      if (obs2[i] !== ev) begin
        n_fail++;
        $display("FAIL busy_gate d2 (%0d,%0d): got %h exp %h", scan_q[i].x, scan_q[i].y, obs2[i], ev);
      end
    end
    repeat (458) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_busy(cnt, bad);
    n_tests++;
    if (cnt != 1200 || bad) begin
      n_fail++;
      $display("FAIL clear_restart_len: got %0d cycles (glitch=%0d) exp 1200", cnt, bad);
    end
    // reset pulse in the middle of a sweep
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy1, wr_ready1, pvo1, act1, px1, fa1} !== {4'b1000, 16'h0000, 10'h000}) begin
      n_fail++;
      $display("FAIL reset_mid: got %b %h %h exp 1000 0000 000", {busy1, wr_ready1, pvo1, act1}, px1, fa1);
    end
    #1 rst_n = 1'b1;
    wait_busy(cnt, bad);
    n_tests++;
    if (cnt != 1200 || bad) begin
      n_fail++;
      $display("FAIL reset_restart_len: got %0d cycles (glitch=%0d) exp 1200", cnt, bad);
    end
    scan_q.delete();
    for (int i = 0; i < 16; i++) scan_q.push_back('{x: i % 8, y: i / 8, en: 1'b1, pv: 1'b1});
    run_scan();
    foreach (scan_q[i]) begin
      model(1'b0, scan_q[i], 1'b0, ev, fv, ef);
      n_tests++;
      if (obs1[i] !== ev || obsfa1[i] !== ef) begin
        n_fail++;
        $display("FAIL after_clear (%0d,%0d): got %h/%h exp %h/%h",
                 scan_q[i].x, scan_q[i].y, obs1[i], obsfa1[i], ev, ef);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_glyph_a();
    test_scaled_region();
    test_transparent_en();
    test_bad_write();
    test_random();
    test_clear_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
